// File: rtl/robo_sequenciador_atuadores.sv
// ============================================================================
// robo_sequenciador_atuadores: expands navigation command pulses into timed
// wheel/arm actuator sequences, with one pending-command slot.
// Revision: 1.0
// ============================================================================
`default_nettype none

module robo_sequenciador_atuadores #(
    parameter int T_AVANCO = 8,
    parameter int T_GIRO   = 12,
    parameter int T_BRACO  = 4,
    parameter int T_GARRA  = 2,
    parameter int CW       = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic avancar,
    input  logic girar,
    input  logic recolher_entulho,
    input  logic pausa,
    output logic motor_esq,
    output logic motor_dir,
    output logic dir_reversa,
    output logic braco_desce,
    output logic garra_fecha,
    output logic braco_sobe,
    output logic ocupado,
    output logic concluido,
    output logic descartado
);

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        AVANCO      = 3'd1,
        GIRO        = 3'd2,
        BRACO_DESCE = 3'd3,
        GARRA       = 3'd4,
        BRACO_SOBE  = 3'd5
    } estado_t;

    localparam logic [1:0] C_CMD_AVANCO  = 2'd0;
    localparam logic [1:0] C_CMD_GIRO    = 2'd1;
    localparam logic [1:0] C_CMD_RECOLHE = 2'd2;

    localparam logic [CW-1:0] C_CARGA_AVANCO = CW'(T_AVANCO - 1);
    localparam logic [CW-1:0] C_CARGA_GIRO   = CW'(T_GIRO - 1);
    localparam logic [CW-1:0] C_CARGA_BRACO  = CW'(T_BRACO - 1);
    localparam logic [CW-1:0] C_CARGA_GARRA  = CW'(T_GARRA - 1);

    estado_t       estado_q;
    logic [CW-1:0] cnt_q;
    logic          pend_v_q;
    logic [1:0]    pend_cmd_q;
    logic          concluido_q;
    logic          descartado_q;

    logic       w_cmd_v;
    logic [1:0] w_cmd;
    logic       w_perde_simul;
    logic       w_fim_seq;

    function automatic estado_t estado_de(input logic [1:0] cmd);
        case (cmd)
            C_CMD_RECOLHE: estado_de = BRACO_DESCE;
            C_CMD_GIRO:    estado_de = GIRO;
            default:       estado_de = AVANCO;
        endcase
    endfunction

    function automatic logic [CW-1:0] carga_de(input logic [1:0] cmd);
        case (cmd)
            C_CMD_RECOLHE: carga_de = C_CARGA_BRACO;
            C_CMD_GIRO:    carga_de = C_CARGA_GIRO;
            default:       carga_de = C_CARGA_AVANCO;
        endcase
    endfunction

    // Priority: recolher_entulho > girar > avancar; losers in the same cycle are dropped.
    assign w_cmd_v       = avancar | girar | recolher_entulho;
    assign w_cmd         = recolher_entulho ? C_CMD_RECOLHE :
                           girar            ? C_CMD_GIRO    : C_CMD_AVANCO;
    assign w_perde_simul = (recolher_entulho & (girar | avancar)) | (girar & avancar);
    assign w_fim_seq     = (cnt_q == '0) && !pausa &&
                           ((estado_q == AVANCO) || (estado_q == GIRO) || (estado_q == BRACO_SOBE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            cnt_q        <= '0;
            pend_v_q     <= 1'b0;
            pend_cmd_q   <= C_CMD_AVANCO;
            concluido_q  <= 1'b0;
            descartado_q <= 1'b0;
        end else begin
            concluido_q  <= 1'b0;
            descartado_q <= w_perde_simul;
            if (estado_q == OCIOSO) begin
                if (w_cmd_v) begin
                    estado_q <= estado_de(w_cmd);
                    cnt_q    <= carga_de(w_cmd);
                end
            end else begin
                // A command in the final cycle with an empty slot starts directly below.
                if (w_cmd_v) begin
                    if (pend_v_q) begin
                        descartado_q <= 1'b1;
                    end else if (!w_fim_seq) begin
                        pend_v_q   <= 1'b1;
                        pend_cmd_q <= w_cmd;
                    end
                end
                if (!pausa) begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        case (estado_q)
                            BRACO_DESCE: begin
                                estado_q <= GARRA;
                                cnt_q    <= C_CARGA_GARRA;
                            end
                            GARRA: begin
                                estado_q <= BRACO_SOBE;
                                cnt_q    <= C_CARGA_BRACO;
                            end
                            default: begin
                                concluido_q <= 1'b1;
                                if (pend_v_q) begin
                                    estado_q <= estado_de(pend_cmd_q);
                                    cnt_q    <= carga_de(pend_cmd_q);
                                    pend_v_q <= 1'b0;
                                end else if (w_cmd_v) begin
                                    estado_q <= estado_de(w_cmd);
                                    cnt_q    <= carga_de(w_cmd);
                                end else begin
                                    estado_q <= OCIOSO;
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end

    assign motor_esq   = ((estado_q == AVANCO) || (estado_q == GIRO)) && !pausa;
    assign motor_dir   = ((estado_q == AVANCO) || (estado_q == GIRO)) && !pausa;
    assign dir_reversa = (estado_q == GIRO) && !pausa;
    assign braco_desce = (estado_q == BRACO_DESCE) && !pausa;
    assign garra_fecha = (estado_q == GARRA) && !pausa;
    assign braco_sobe  = (estado_q == BRACO_SOBE) && !pausa;
    assign ocupado     = (estado_q != OCIOSO);
    assign concluido   = concluido_q;
    assign descartado  = descartado_q;

endmodule

`default_nettype wire
